// File: rtl/cyclo_pkg.sv
// Shared constants for the cyclostationary front end: default data width,
// corner-turn geometry and the address widths derived from it.
package cyclo_pkg;

   localparam int CT_NB_DATA = 16;
   localparam int CT_P       = 32;
   localparam int CT_NP      = 1024;

   function automatic int ct_clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   localparam int CT_BIN_W       = ct_clog2(CT_NP);
   localparam int CT_BLK_W       = ct_clog2(CT_P);
   localparam int CT_BANK_ADDR_W = CT_BIN_W + CT_BLK_W;
   localparam int CT_RAM_ADDR_W  = CT_BANK_ADDR_W + 1;

endpackage

// File: rtl/ct_bank_ram.sv
// Two-bank corner-turn storage: one write port, one registered read port.
// The bank select is the address MSB; the array itself carries no reset.
module ct_bank_ram
   import cyclo_pkg::*;
#(
   parameter int DW = 2 * CT_NB_DATA,
   parameter int AW = CT_RAM_ADDR_W
) (
   input  logic          clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] mem_q [1 << AW];
   logic [DW-1:0] rdata_q;

   // write port
   always_ff @(posedge clock) begin
      if (i_we) mem_q[i_waddr] <= i_wdata;
   end

   // read port, one cycle of latency, output held between reads
   always_ff @(posedge clock) begin
      if (i_re) rdata_q <= mem_q[i_raddr];
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/corner_turn_buffer.sv
// Ping-pong corner turn: rows of NP bins are written block-major into one
// bank while the other bank is replayed column-wise (per channel k, P samples).
// Build option CORNER_TURN_CONJ_OUT_EN: output imag is the saturated negation
// of the stored imag (conjugate output); otherwise imag passes unmodified.
module corner_turn_buffer
   import cyclo_pkg::*;
#(
   parameter int P       = CT_P,
   parameter int NP      = CT_NP,
   parameter int NB_DATA = CT_NB_DATA
) (
   input  logic                      clock,
   input  logic                      i_reset,
   input  logic                      i_enable,
   input  logic signed [NB_DATA-1:0] i_s_tdata_real,
   input  logic signed [NB_DATA-1:0] i_s_tdata_imag,
   input  logic                      i_s_tvalid,
   input  logic                      i_s_tlast,
   output logic                      o_s_tready,
   output logic signed [NB_DATA-1:0] o_m_tdata_real,
   output logic signed [NB_DATA-1:0] o_m_tdata_imag,
   output logic [$clog2(NP)-1:0]     o_m_tuser,
   output logic                      o_m_tvalid,
   output logic                      o_m_tlast,
   input  logic                      i_m_tready,
   output logic                      o_tlast_error
);

   localparam int BIN_W  = ct_clog2(NP);
   localparam int BLK_W  = ct_clog2(P);
   localparam int ADDR_W = BLK_W + BIN_W + 1;
   localparam int DW     = 2 * NB_DATA;
   localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NP - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(P - 1);

   typedef struct packed {
      logic signed [NB_DATA-1:0] re;
      logic signed [NB_DATA-1:0] im;
      logic [BIN_W-1:0]          k;
      logic                      last;
      logic                      eof;
   } beat_t;

`ifdef CORNER_TURN_CONJ_OUT_EN
   function automatic logic signed [NB_DATA-1:0] sat_neg(input logic signed [NB_DATA-1:0] x);
      logic signed [NB_DATA-1:0] r;
      if (x == {1'b1, {(NB_DATA-1){1'b0}}}) r = {1'b0, {(NB_DATA-1){1'b1}}};
      else                                  r = -x;
      return r;
   endfunction
`endif

   // write side state
   logic             wbank_q, wbank_d;
   logic [BLK_W-1:0] wblk_q, wblk_d;
   logic [BIN_W-1:0] wbin_q, wbin_d;
   logic [1:0]       full_q, full_d;
   logic             err_q, err_d;
   // read address generation state
   logic             rbank_q, rbank_d;
   logic [BLK_W-1:0] rblk_q, rblk_d;
   logic [BIN_W-1:0] rk_q, rk_d;
   logic             issued_q, issued_d;
   // sideband travelling with the RAM read
   logic             rd_vld_q, rd_vld_d;
   logic [BIN_W-1:0] rd_k_q, rd_k_d;
   logic             rd_last_q, rd_last_d;
   logic             rd_eof_q, rd_eof_d;
   // two-entry output skid
   beat_t [1:0]      ent_q, ent_d;
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic [1:0]       cnt_q, cnt_d;

   logic                      wr_fire, bin_end, pop, drain_done, skid_room, rd_issue;
   logic [DW-1:0]             ram_rdata;
   logic signed [NB_DATA-1:0] rd_re, rd_im;
   beat_t                     head;

   assign o_s_tready = ~i_reset & i_enable & ~full_q[wbank_q];
   assign wr_fire    = o_s_tready & i_s_tvalid;
   assign bin_end    = (wbin_q == BIN_LAST);
   assign head       = ent_q[rptr_q];
   assign o_m_tvalid = (cnt_q != 2'd0);
   assign pop        = o_m_tvalid & i_m_tready;
   assign drain_done = pop & head.eof;
   // count the read in flight so the skid can never overflow
   assign skid_room  = (cnt_q == 2'd0) | ((cnt_q == 2'd1) & (~rd_vld_q | pop)) |
                       ((cnt_q == 2'd2) & pop & ~rd_vld_q);
   assign rd_issue   = i_enable & full_q[rbank_q] & ~issued_q & skid_room;

   ct_bank_ram #(.DW(DW), .AW(ADDR_W)) u_ram (
      .clock   (clock),
      .i_we    (wr_fire),
      .i_waddr ({wbank_q, wblk_q, wbin_q}),
      .i_wdata ({i_s_tdata_real, i_s_tdata_imag}),
      .i_re    (rd_issue),
      .i_raddr ({rbank_q, rblk_q, rk_q}),
      .o_rdata (ram_rdata)
   );

   assign rd_re = ram_rdata[DW-1:NB_DATA];
   assign rd_im = ram_rdata[NB_DATA-1:0];

   // row/block counting, tlast check and bank hand-off between writer and reader
   always_comb begin
      wbank_d = wbank_q;
      wblk_d  = wblk_q;
      wbin_d  = wbin_q;
      full_d  = full_q;
      rbank_d = rbank_q;
      err_d   = 1'b0;
      if (wr_fire) begin
         err_d = i_s_tlast ^ bin_end;
         if (i_s_tlast | bin_end) begin
            // an early tlast resyncs to the next row; unwritten bins keep old data
            wbin_d = '0;
            if (wblk_q == BLK_LAST) begin
               wblk_d         = '0;
               full_d[wbank_q] = 1'b1;
               wbank_d        = ~wbank_q;
            end else begin
               wblk_d = wblk_q + 1'b1;
            end
         end else begin
            wbin_d = wbin_q + 1'b1;
         end
      end
      if (drain_done) begin
         full_d[rbank_q] = 1'b0;
         rbank_d         = ~rbank_q;
      end
   end

   // column-order address walk: block fastest, then channel
   always_comb begin
      rblk_d    = rblk_q;
      rk_d      = rk_q;
      issued_d  = issued_q;
      rd_vld_d  = rd_issue;
      rd_k_d    = rd_k_q;
      rd_last_d = rd_last_q;
      rd_eof_d  = rd_eof_q;
      if (rd_issue) begin
         rd_k_d    = rk_q;
         rd_last_d = (rblk_q == BLK_LAST);
         rd_eof_d  = (rblk_q == BLK_LAST) & (rk_q == BIN_LAST);
         if (rblk_q == BLK_LAST) begin
            rblk_d = '0;
            if (rk_q == BIN_LAST) begin
               rk_d     = '0;
               issued_d = 1'b1;
            end else begin
               rk_d = rk_q + 1'b1;
            end
         end else begin
            rblk_d = rblk_q + 1'b1;
         end
      end
      if (drain_done) issued_d = 1'b0;
   end

   // skid push from the RAM output register, pop on downstream handshake
   always_comb begin
      ent_d  = ent_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
      if (rd_vld_q) begin
         ent_d[wptr_q].re   = rd_re;
`ifdef CORNER_TURN_CONJ_OUT_EN
         ent_d[wptr_q].im   = sat_neg(rd_im);
`else
         ent_d[wptr_q].im   = rd_im;
`endif
         ent_d[wptr_q].k    = rd_k_q;
         ent_d[wptr_q].last = rd_last_q;
         ent_d[wptr_q].eof  = rd_eof_q;
         wptr_d             = ~wptr_q;
      end
      if (pop) rptr_d = ~rptr_q;
   end

   // state registers; reset empties both banks and clears the outputs
   always_ff @(posedge clock or posedge i_reset) begin
      if (i_reset) begin
         wbank_q   <= 1'b0;
         wblk_q    <= '0;
         wbin_q    <= '0;
         full_q    <= '0;
         err_q     <= 1'b0;
         rbank_q   <= 1'b0;
         rblk_q    <= '0;
         rk_q      <= '0;
         issued_q  <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_k_q    <= '0;
         rd_last_q <= 1'b0;
         rd_eof_q  <= 1'b0;
         ent_q     <= '0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         wbank_q   <= wbank_d;
         wblk_q    <= wblk_d;
         wbin_q    <= wbin_d;
         full_q    <= full_d;
         err_q     <= err_d;
         rbank_q   <= rbank_d;
         rblk_q    <= rblk_d;
         rk_q      <= rk_d;
         issued_q  <= issued_d;
         rd_vld_q  <= rd_vld_d;
         rd_k_q    <= rd_k_d;
         rd_last_q <= rd_last_d;
         rd_eof_q  <= rd_eof_d;
         ent_q     <= ent_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign o_m_tdata_real = head.re;
   assign o_m_tdata_imag = head.im;
   assign o_m_tuser      = head.k;
   assign o_m_tlast      = head.last;
   assign o_tlast_error  = err_q;

endmodule
